// File: rtl/bip_control.sv
// bip_control: multi-cycle FETCH/DECODE/MEM/EXEC control unit for the accumulator processor.
// Every output is a register; strobes are loaded on the edge entering the state that owns them.
module bip_control #(
    parameter int NBITS_D  = 16,
    parameter int NBITS_O  = 11,
    parameter int NBITS_OP = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [NBITS_D-1:0] i_Instruction,
    output logic [NBITS_O-1:0] o_PC,
    output logic [NBITS_O-1:0] o_Operand,
    output logic [1:0]         o_SelA,
    output logic               o_SelB,
    output logic               o_WrAcc,
    output logic               o_Op,
    output logic               o_RdRam,
    output logic               o_WrRam,
    output logic               o_halt,
    output logic [15:0]        o_icount
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEM    = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [NBITS_OP-1:0] OP_HLT  = NBITS_OP'(0);
    localparam logic [NBITS_OP-1:0] OP_STO  = NBITS_OP'(1);
    localparam logic [NBITS_OP-1:0] OP_LD   = NBITS_OP'(2);
    localparam logic [NBITS_OP-1:0] OP_LDI  = NBITS_OP'(3);
    localparam logic [NBITS_OP-1:0] OP_ADD  = NBITS_OP'(4);
    localparam logic [NBITS_OP-1:0] OP_ADDI = NBITS_OP'(5);
    localparam logic [NBITS_OP-1:0] OP_SUB  = NBITS_OP'(6);
    localparam logic [NBITS_OP-1:0] OP_SUBI = NBITS_OP'(7);

    state_t              state_q;
    logic [NBITS_O-1:0]  pc_q;
    logic [NBITS_D-1:0]  ir_q;
    logic [1:0]          selA_q;
    logic                selB_q;
    logic                op_q;
    logic                wrAcc_q;
    logic                rdRam_q;
    logic                wrRam_q;
    logic                halt_q;
    logic [15:0]         icount_q;

    logic [NBITS_OP-1:0] opcode_d;
    logic [1:0]          selA_d;
    logic                selB_d;
    logic                op_d;
    logic                wrAcc_d;
    logic                wrRam_d;
    logic                isMemOp_d;

    // In DECODE the opcode comes straight from memory; in MEM it comes from the latched IR.
    always_comb begin
        opcode_d  = (state_q == DECODE) ? i_Instruction[NBITS_D-1 -: NBITS_OP]
                                        : ir_q[NBITS_D-1 -: NBITS_OP];
        selA_d    = 2'b00;
        selB_d    = 1'b0;
        op_d      = 1'b0;
        wrAcc_d   = 1'b0;
        wrRam_d   = 1'b0;
        isMemOp_d = 1'b0;
        case (opcode_d)
            OP_STO:  wrRam_d = 1'b1;
            OP_LD:   begin wrAcc_d = 1'b1; isMemOp_d = 1'b1; end
            OP_LDI:  begin selA_d = 2'b01; wrAcc_d = 1'b1; end
            OP_ADD:  begin selA_d = 2'b10; wrAcc_d = 1'b1; isMemOp_d = 1'b1; end
            OP_ADDI: begin selA_d = 2'b10; selB_d = 1'b1; wrAcc_d = 1'b1; end
            OP_SUB:  begin selA_d = 2'b10; op_d = 1'b1; wrAcc_d = 1'b1; isMemOp_d = 1'b1; end
            OP_SUBI: begin selA_d = 2'b10; selB_d = 1'b1; op_d = 1'b1; wrAcc_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            selA_q   <= 2'b00;
            selB_q   <= 1'b0;
            op_q     <= 1'b0;
            wrAcc_q  <= 1'b0;
            rdRam_q  <= 1'b0;
            wrRam_q  <= 1'b0;
            halt_q   <= 1'b0;
            icount_q <= '0;
        end else begin
            // Strobes live for exactly one cycle unless reloaded below.
            selA_q  <= 2'b00;
            selB_q  <= 1'b0;
            op_q    <= 1'b0;
            wrAcc_q <= 1'b0;
            rdRam_q <= 1'b0;
            wrRam_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (i_enable) state_q <= DECODE;
                end
                DECODE: begin
                    ir_q <= i_Instruction;
                    if (opcode_d == OP_HLT) begin
                        state_q  <= HALT;
                        halt_q   <= 1'b1;
                        icount_q <= icount_q + 16'd1;
                    end else if (isMemOp_d) begin
                        state_q <= MEM;
                        rdRam_q <= 1'b1;
                    end else begin
                        state_q <= EXEC;
                        selA_q  <= selA_d;
                        selB_q  <= selB_d;
                        op_q    <= op_d;
                        wrAcc_q <= wrAcc_d;
                        wrRam_q <= wrRam_d;
                    end
                end
                MEM: begin
                    state_q <= EXEC;
                    selA_q  <= selA_d;
                    selB_q  <= selB_d;
                    op_q    <= op_d;
                    wrAcc_q <= wrAcc_d;
                    wrRam_q <= wrRam_d;
                end
                EXEC: begin
                    state_q  <= FETCH;
                    pc_q     <= pc_q + NBITS_O'(1);
                    icount_q <= icount_q + 16'd1;
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign o_PC      = pc_q;
    assign o_Operand = ir_q[NBITS_O-1:0];
    assign o_SelA    = selA_q;
    assign o_SelB    = selB_q;
    assign o_Op      = op_q;
    assign o_WrAcc   = wrAcc_q;
    assign o_RdRam   = rdRam_q;
    assign o_WrRam   = wrRam_q;
    assign o_halt    = halt_q;
    assign o_icount  = icount_q;

endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: randomized and directed programs for bip_control, checked against an
// instruction-level reference model (cycle count and strobe set per opcode).
module tb_bip_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] instr;
    logic [10:0] pc;
    logic [10:0] operand;
    logic [1:0]  selA;
    logic        selB;
    logic        wrAcc;
    logic        op;
    logic        rdRam;
    logic        wrRam;
    logic        halt;
    logic [15:0] icount;

    logic [15:0] imem [0:2047];
    int checks = 0;
    int errors = 0;

    bip_control dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (enable),
        .i_Instruction(instr),
        .o_PC         (pc),
        .o_Operand    (operand),
        .o_SelA       (selA),
        .o_SelB       (selB),
        .o_WrAcc      (wrAcc),
        .o_Op         (op),
        .o_RdRam      (rdRam),
        .o_WrRam      (wrRam),
        .o_halt       (halt),
        .o_icount     (icount)
    );

    always #5 clk = ~clk;

    // Instruction memory with one cycle of read latency.
    always @(posedge clk) instr <= imem[pc];

    typedef struct {
        int          cycles;
        int          nWrAcc;
        int          nWrRam;
        int          nRdRam;
        int          rdIdx;
        int          wrIdx;
        int          badIdle;
        logic [1:0]  selA;
        logic        selB;
        logic        op;
        logic [10:0] rdAddr;
        logic [10:0] wrAddr;
        logic [10:0] pcAfter;
        logic [15:0] icAfter;
        logic        haltAfter;
    } obs_t;

    typedef struct {
        int         cycles;
        int         nWrAcc;
        int         nWrRam;
        int         nRdRam;
        logic [1:0] selA;
        logic       selB;
        logic       op;
        logic       alu;
        logic       halts;
    } exp_t;

    // What one instruction should do, straight from the opcode table.
    function automatic exp_t model(input logic [15:0] ins);
        exp_t e;
        logic [4:0] opc;
        opc = ins[15:11];
        e = '{cycles: 3, nWrAcc: 0, nWrRam: 0, nRdRam: 0, selA: 2'b00, selB: 1'b0,
              op: 1'b0, alu: 1'b0, halts: 1'b0};
        case (opc)
            5'd0: begin e.cycles = 2; e.halts = 1'b1; end
            5'd1: e.nWrRam = 1;
            5'd2: begin e.cycles = 4; e.nRdRam = 1; e.nWrAcc = 1; e.selA = 2'b00; end
            5'd3: begin e.nWrAcc = 1; e.selA = 2'b01; end
            5'd4: begin e.cycles = 4; e.nRdRam = 1; e.nWrAcc = 1; e.selA = 2'b10; e.alu = 1'b1; end
            5'd5: begin e.nWrAcc = 1; e.selA = 2'b10; e.selB = 1'b1; e.alu = 1'b1; end
            5'd6: begin e.cycles = 4; e.nRdRam = 1; e.nWrAcc = 1; e.selA = 2'b10; e.op = 1'b1; e.alu = 1'b1; end
            5'd7: begin e.nWrAcc = 1; e.selA = 2'b10; e.selB = 1'b1; e.op = 1'b1; e.alu = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [15:0] rand_non_halt();
        logic [4:0] opc;
        if ($urandom_range(0, 3) != 0) opc = 5'($urandom_range(1, 7));
        else opc = 5'($urandom_range(8, 31));
        return {opc, 11'($urandom)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Watches one instruction, starting at the negedge of its FETCH cycle; ends at the next FETCH or HALT.
    task automatic observe(output obs_t ob);
        logic [10:0] start;
        ob = '{default: 0};
        start = pc;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (pc !== start || halt === 1'b1) break;
            end
            ob.cycles = ob.cycles + 1;
            if (wrAcc) begin ob.nWrAcc = ob.nWrAcc + 1; ob.wrIdx = ob.cycles; end
            if (wrRam) begin ob.nWrRam = ob.nWrRam + 1; ob.wrIdx = ob.cycles; ob.wrAddr = operand; end
            if (rdRam) begin ob.nRdRam = ob.nRdRam + 1; ob.rdIdx = ob.cycles; ob.rdAddr = operand; end
            ob.selA = selA;
            ob.selB = selB;
            ob.op   = op;
            if (ob.cycles <= 2 && (selA != 2'b00 || selB || op || wrAcc || wrRam || rdRam))
                ob.badIdle = ob.badIdle + 1;
        end
        ob.pcAfter   = pc;
        ob.icAfter   = icount;
        ob.haltAfter = halt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2048; i++) imem[i] = 16'h4000;
        repeat (2) @(negedge clk);
        checks++;
        if ({pc, operand, selA, selB, wrAcc, op, rdRam, wrRam, halt, icount} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs pc=%h operand=%h selA=%b selB=%b wrAcc=%b op=%b rd=%b wr=%b halt=%b ic=%h required all zero",
                     pc, operand, selA, selB, wrAcc, op, rdRam, wrRam, halt, icount);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pc !== 11'd0 || wrAcc !== 1'b0 || rdRam !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release pc=%h wrAcc=%b rdRam=%b required 0/0/0", pc, wrAcc, rdRam);
        end
    endtask

    task automatic test_ldi_addi_hlt();
        int wt[2];
        logic [3:0] ws[2];
        int nw;
        int firstHalt;
        int strobeAfterHalt;
        imem[0] = 16'h1805;
        imem[1] = 16'h2803;
        imem[2] = 16'h0000;
        do_reset();
        nw = 0; firstHalt = -1; strobeAfterHalt = 0;
        wt[0] = -1; wt[1] = -1; ws[0] = '0; ws[1] = '0;
        for (int t = 0; t < 14; t++) begin
            if (t > 0) @(negedge clk);
            if (wrAcc) begin
                if (nw < 2) begin wt[nw] = t; ws[nw] = {selA, selB, op}; end
                nw++;
            end
            if (halt && firstHalt < 0) firstHalt = t;
            if (firstHalt >= 0 && (wrAcc || wrRam || rdRam || selA != 2'b00)) strobeAfterHalt++;
        end
        checks++;
        if (nw != 2) begin errors++; $display("[TB] FAIL prog1_wracc_count got %0d required 2", nw); end
        checks++;
        if (wt[0] != 2 || ws[0] !== 4'b0100) begin
            errors++; $display("[TB] FAIL prog1_ldi got cycle %0d sel %b required cycle 2 sel 0100", wt[0], ws[0]);
        end
        checks++;
        if (wt[1] != 5 || ws[1] !== 4'b1010) begin
            errors++; $display("[TB] FAIL prog1_addi got cycle %0d sel %b required cycle 5 sel 1010", wt[1], ws[1]);
        end
        checks++;
        if (firstHalt != 8) begin errors++; $display("[TB] FAIL prog1_halt_cycle got %0d required 8", firstHalt); end
        checks++;
        if (icount !== 16'd3 || pc !== 11'd2) begin
            errors++; $display("[TB] FAIL prog1_final got ic=%0d pc=%0d required ic=3 pc=2", icount, pc);
        end
        checks++;
        if (strobeAfterHalt != 0) begin
            errors++; $display("[TB] FAIL prog1_halt_quiet got %0d strobe cycles required 0", strobeAfterHalt);
        end
    endtask

    task automatic test_mem_program();
        obs_t ob;
        imem[0] = 16'h1010;
        imem[1] = 16'h3011;
        imem[2] = 16'h0812;
        do_reset();
        observe(ob);
        checks++;
        if (ob.cycles != 4 || ob.nRdRam != 1 || ob.rdAddr !== 11'h010 || ob.rdIdx != 3) begin
            errors++;
            $display("[TB] FAIL mem_ld got cyc=%0d rd=%0d addr=%h idx=%0d required 4/1/010/3",
                     ob.cycles, ob.nRdRam, ob.rdAddr, ob.rdIdx);
        end
        checks++;
        if (ob.nWrAcc != 1 || ob.wrIdx != 4 || ob.selA !== 2'b00) begin
            errors++; $display("[TB] FAIL mem_ld_wracc got n=%0d idx=%0d selA=%b required 1/4/00", ob.nWrAcc, ob.wrIdx, ob.selA);
        end
        observe(ob);
        checks++;
        if (ob.cycles != 4 || ob.nRdRam != 1 || ob.rdAddr !== 11'h011 || ob.rdIdx != 3) begin
            errors++;
            $display("[TB] FAIL mem_sub_rd got cyc=%0d rd=%0d addr=%h idx=%0d required 4/1/011/3",
                     ob.cycles, ob.nRdRam, ob.rdAddr, ob.rdIdx);
        end
        checks++;
        if (ob.nWrAcc != 1 || {ob.selA, ob.selB, ob.op} !== 4'b1001) begin
            errors++; $display("[TB] FAIL mem_sub_exec got n=%0d sel=%b required 1/1001", ob.nWrAcc, {ob.selA, ob.selB, ob.op});
        end
        observe(ob);
        checks++;
        if (ob.cycles != 3 || ob.nWrRam != 1 || ob.wrAddr !== 11'h012 || ob.nWrAcc != 0 || ob.nRdRam != 0) begin
            errors++;
            $display("[TB] FAIL mem_sto got cyc=%0d wr=%0d addr=%h acc=%0d rd=%0d required 3/1/012/0/0",
                     ob.cycles, ob.nWrRam, ob.wrAddr, ob.nWrAcc, ob.nRdRam);
        end
    endtask

    task automatic test_enable();
        obs_t ob;
        int bad;
        for (int i = 0; i < 4; i++) imem[i] = rand_non_halt();
        imem[4] = {5'd3, 11'($urandom)};
        do_reset();
        for (int i = 0; i < 4; i++) observe(ob);
        checks++;
        if (pc !== 11'd4) begin errors++; $display("[TB] FAIL enable_setup pc got %0d required 4", pc); end
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pc !== 11'd4 || wrAcc || wrRam || rdRam || selA != 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL enable_stall got %0d bad cycles required 0", bad); end
        enable = 1'b1;
        observe(ob);
        checks++;
        if (ob.cycles != 3 || ob.nWrAcc != 1 || ob.selA !== 2'b01 || ob.pcAfter !== 11'd5 || ob.icAfter !== 16'd5) begin
            errors++;
            $display("[TB] FAIL enable_resume got cyc=%0d acc=%0d selA=%b pc=%0d ic=%0d required 3/1/01/5/5",
                     ob.cycles, ob.nWrAcc, ob.selA, ob.pcAfter, ob.icAfter);
        end
    endtask

    task automatic test_random_program();
        obs_t ob;
        exp_t ex;
        logic [15:0] ins;
        logic [15:0] ic;
        for (int i = 0; i < 24; i++) imem[i] = rand_non_halt();
        imem[7] = {5'b11111, 11'($urandom)};
        do_reset();
        ic = 16'd0;
        for (int i = 0; i < 24; i++) begin
            ins = imem[i];
            ex = model(ins);
            ic = ic + 16'd1;
            observe(ob);
            checks++;
            if (ob.cycles != ex.cycles) begin
                errors++; $display("[TB] FAIL rnd_cycles pc=%0d ins=%h got %0d required %0d", i, ins, ob.cycles, ex.cycles);
            end
            checks++;
            if (ob.nWrAcc != ex.nWrAcc || ob.nWrRam != ex.nWrRam || ob.nRdRam != ex.nRdRam) begin
                errors++;
                $display("[TB] FAIL rnd_strobes pc=%0d ins=%h got acc/wr/rd=%0d/%0d/%0d required %0d/%0d/%0d",
                         i, ins, ob.nWrAcc, ob.nWrRam, ob.nRdRam, ex.nWrAcc, ex.nWrRam, ex.nRdRam);
            end
            checks++;
            if (ob.badIdle != 0) begin
                errors++; $display("[TB] FAIL rnd_idle pc=%0d got %0d active fetch/decode cycles required 0", i, ob.badIdle);
            end
            if (ex.nWrAcc + ex.nWrRam > 0) begin
                checks++;
                if (ob.wrIdx != ex.cycles) begin
                    errors++; $display("[TB] FAIL rnd_write_slot pc=%0d got %0d required %0d", i, ob.wrIdx, ex.cycles);
                end
            end
            if (ex.nWrAcc > 0) begin
                checks++;
                if (ob.selA !== ex.selA) begin
                    errors++; $display("[TB] FAIL rnd_selA pc=%0d got %b required %b", i, ob.selA, ex.selA);
                end
            end
            if (ex.alu) begin
                checks++;
                if (ob.selB !== ex.selB || ob.op !== ex.op) begin
                    errors++; $display("[TB] FAIL rnd_alu pc=%0d got selB=%b op=%b required %b/%b", i, ob.selB, ob.op, ex.selB, ex.op);
                end
            end
            if (ex.nRdRam > 0) begin
                checks++;
                if (ob.rdAddr !== ins[10:0] || ob.rdIdx != ex.cycles - 1) begin
                    errors++;
                    $display("[TB] FAIL rnd_read pc=%0d got addr=%h idx=%0d required %h/%0d",
                             i, ob.rdAddr, ob.rdIdx, ins[10:0], ex.cycles - 1);
                end
            end
            if (ex.nWrRam > 0) begin
                checks++;
                if (ob.wrAddr !== ins[10:0]) begin
                    errors++; $display("[TB] FAIL rnd_store_addr pc=%0d got %h required %h", i, ob.wrAddr, ins[10:0]);
                end
            end
            checks++;
            if (ob.pcAfter !== 11'(i + 1) || ob.icAfter !== ic || ob.haltAfter !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rnd_progress pc=%0d got pc=%0d ic=%0d halt=%b required %0d/%0d/0",
                         i, ob.pcAfter, ob.icAfter, ob.haltAfter, i + 1, ic);
            end
            if (i == 7) begin
                checks++;
                if (ob.cycles != 3 || ob.nWrAcc + ob.nWrRam + ob.nRdRam != 0 || ob.pcAfter !== 11'd8) begin
                    errors++;
                    $display("[TB] FAIL nop_11111 got cyc=%0d strobes=%0d pc=%0d required 3/0/8",
                             ob.cycles, ob.nWrAcc + ob.nWrRam + ob.nRdRam, ob.pcAfter);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t ob;
        int bad;
        imem[0] = {5'd3, 11'($urandom)};
        imem[1] = {5'd4, 11'($urandom)};
        do_reset();
        observe(ob);
        checks++;
        if (ob.icAfter !== 16'd1 || ob.pcAfter !== 11'd1) begin
            errors++; $display("[TB] FAIL abort_setup got ic=%0d pc=%0d required 1/1", ob.icAfter, ob.pcAfter);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rdRam !== 1'b1) begin errors++; $display("[TB] FAIL abort_mem_rd got %b required 1", rdRam); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rdRam !== 1'b0) begin errors++; $display("[TB] FAIL abort_async_rd got %b required 0", rdRam); end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wrAcc || wrRam || rdRam) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL abort_quiet got %0d strobe cycles required 0", bad); end
        rst = 1'b0;
        checks++;
        if (pc !== 11'd0 || icount !== 16'd0) begin
            errors++; $display("[TB] FAIL abort_state got pc=%0d ic=%0d required 0/0", pc, icount);
        end
        observe(ob);
        checks++;
        if (ob.cycles != 3 || ob.nWrAcc != 1 || ob.selA !== 2'b01 || ob.pcAfter !== 11'd1) begin
            errors++;
            $display("[TB] FAIL abort_restart got cyc=%0d acc=%0d selA=%b pc=%0d required 3/1/01/1",
                     ob.cycles, ob.nWrAcc, ob.selA, ob.pcAfter);
        end
    endtask

    task automatic test_wrap();
        obs_t ob;
        int bad;
        for (int i = 0; i < 2048; i++) imem[i] = {5'($urandom_range(8, 31)), 11'($urandom)};
        do_reset();
        bad = 0;
        for (int i = 0; i < 2047; i++) begin
            observe(ob);
            if (ob.cycles != 3 || ob.nWrAcc + ob.nWrRam + ob.nRdRam != 0 || ob.pcAfter !== 11'(i + 1)) bad++;
        end
        checks++;
        if (bad != 0 || pc !== 11'd2047) begin
            errors++; $display("[TB] FAIL wrap_walk got %0d bad nops pc=%0d required 0 and 2047", bad, pc);
        end
        observe(ob);
        checks++;
        if (ob.pcAfter !== 11'd0 || ob.icAfter !== 16'd2048) begin
            errors++; $display("[TB] FAIL wrap_pc got pc=%0d ic=%0d required 0/2048", ob.pcAfter, ob.icAfter);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_ldi_addi_hlt();
        test_mem_program();
        test_enable();
        test_random_program();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
